// File: rtl/turbo_enc_mb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : turbo_enc_mb_ctrl
// Description : Multi-bank frame controller for a turbo encoder. Round-robin
//               bank arbitration, ROM/fetch/RSC enable sequencing, trellis
//               termination and FIFO-overflow recovery. The optional frame and
//               abort counters are built when TURBO_ENC_FRAME_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module turbo_enc_mb_ctrl #(
  parameter int NBANK    = 2,
  parameter int PIPE_LAT = 2,
  parameter int TERM_LEN = 4,
  parameter int WARN_CYC = 1000,
  parameter int RST_CYC  = 10
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NBANK-1:0]                          i_bank_done,
  input  logic [1:0]                                i_k_sel,
  input  logic                                      fifo_overflow,
  output logic                                      rom_en,
  output logic                                      fetch_en,
  output logic                                      rsc_en,
  output logic                                      o_term,
  output logic                                      enc_start,
  output logic                                      enc_done,
  output logic                                      alert,
  output logic [NBANK-1:0]                          o_bank_ack,
  output logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] o_bank_sel,
  output logic [13:0]                               o_k,
  output logic                                      soft_rst,
  output logic                                      data_in_ctrl
`ifdef TURBO_ENC_FRAME_CNT_EN
  ,
  output logic [15:0]                               o_frame_cnt,
  output logic [7:0]                                o_abort_cnt
`endif
);

  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int TW = (TERM_LEN > 1) ? $clog2(TERM_LEN) : 1;
  localparam int WW = $clog2(WARN_CYC + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ENC  = 2'd1;
  localparam logic [1:0] S_TERM = 2'd2;
  localparam logic [1:0] S_WARN = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [13:0]         rom_cnt;
  logic [13:0]         rsc_cnt;
  logic [TW-1:0]       term_cnt;
  logic [WW-1:0]       warn_cnt;
  logic [BW-1:0]       last_served;
  logic [PIPE_LAT-1:0] pipe;
  logic                fetch_q;

  logic [NBANK-1:0]    cand;
  logic [BW-1:0]       base;
  logic                pick_valid;
  logic [BW-1:0]       pick;
  logic                go_warn;
  logic                term_last;
  logic                warn_last;
  logic                start_frame;

  function automatic logic [13:0] k_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return 14'd1784;
      2'd1:    return 14'd3568;
      2'd2:    return 14'd7136;
      default: return 14'd8920;
    endcase
  endfunction

  // In TERM the bank being released is masked and the search starts after it,
  // so the next frame can follow without passing through IDLE.
  always_comb begin
    cand       = i_bank_done;
    base       = last_served;
    pick_valid = 1'b0;
    pick       = '0;
    if (state == S_TERM) begin
      cand[o_bank_sel] = 1'b0;
      base             = o_bank_sel;
    end
    for (int i = NBANK; i >= 1; i--) begin
      if (cand[(int'(base) + i) % NBANK]) begin
        pick_valid = 1'b1;
        pick       = BW'((int'(base) + i) % NBANK);
      end
    end
  end

  assign rom_en      = (state == S_ENC) && (rom_cnt != o_k);
  assign fetch_en    = fetch_q;
  assign rsc_en      = pipe[PIPE_LAT-1];
  assign enc_start   = (state == S_ENC) && (rom_cnt == 14'd0);
  assign enc_done    = (state == S_ENC) && rsc_en && (rsc_cnt == o_k - 14'd1);
  assign o_term      = (state == S_TERM);
  assign alert       = (state == S_WARN);
  assign term_last   = o_term && (term_cnt == TW'(TERM_LEN - 1));
  assign warn_last   = alert && (warn_cnt == WW'(WARN_CYC));
  assign soft_rst    = alert && (int'(warn_cnt) < RST_CYC);
  assign go_warn     = fifo_overflow && (state != S_WARN);
  assign start_frame = !go_warn && pick_valid && ((state == S_IDLE) || term_last);
  assign o_bank_ack  = (term_last && !fifo_overflow) ? (NBANK'(1) << o_bank_sel) : '0;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (go_warn)         state_next = S_WARN;
        else if (pick_valid) state_next = S_ENC;
      end
      S_ENC: begin
        if (go_warn)       state_next = S_WARN;
        else if (enc_done) state_next = S_TERM;
      end
      S_TERM: begin
        if (go_warn)        state_next = S_WARN;
        else if (term_last) state_next = pick_valid ? S_ENC : S_IDLE;
      end
      default: begin
        if (warn_last) state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rom_cnt      <= '0;
      rsc_cnt      <= '0;
      term_cnt     <= '0;
      warn_cnt     <= '0;
      last_served  <= BW'(NBANK - 1);
      pipe         <= '0;
      fetch_q      <= 1'b0;
      o_bank_sel   <= '0;
      o_k          <= 14'd8920;
      data_in_ctrl <= 1'b1;
    end else begin
      state        <= state_next;
      data_in_ctrl <= (state != S_WARN);

      if (go_warn) begin
        pipe    <= '0;
        fetch_q <= 1'b0;
      end else begin
        fetch_q <= rom_en;
        pipe[0] <= rom_en;
        for (int i = 1; i < PIPE_LAT; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end

      if (start_frame) begin
        o_bank_sel <= pick;
        o_k        <= k_of(i_k_sel);
        rom_cnt    <= '0;
        rsc_cnt    <= '0;
      end else if (state == S_ENC) begin
        if (rom_en) rom_cnt <= rom_cnt + 14'd1;
        if (rsc_en) rsc_cnt <= rsc_cnt + 14'd1;
      end

      if (go_warn || term_last) begin
        term_cnt <= '0;
      end else if (o_term) begin
        term_cnt <= term_cnt + TW'(1);
      end
      if (term_last && !fifo_overflow) begin
        last_served <= o_bank_sel;
      end

      // Leaving WARN hands priority back to bank 0.
      if (warn_last) begin
        warn_cnt    <= '0;
        last_served <= BW'(NBANK - 1);
      end else if (alert) begin
        warn_cnt <= warn_cnt + WW'(1);
      end
    end
  end

`ifdef TURBO_ENC_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_frame_cnt <= '0;
      o_abort_cnt <= '0;
    end else begin
      if (|o_bank_ack) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
      if (go_warn && ((state == S_ENC) || (state == S_TERM)) && (o_abort_cnt != 8'hFF)) begin
        o_abort_cnt <= o_abort_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_turbo_enc_mb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_turbo_enc_mb_ctrl
// Description : Directed self-checking bench for turbo_enc_mb_ctrl with a
//               scoreboard of expected frames (bank, block length).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turbo_enc_mb_ctrl;

  localparam int NBANK    = 4;
  localparam int PIPE_LAT = 2;
  localparam int TERM_LEN = 4;
  localparam int WARN_CYC = 1000;
  localparam int RST_CYC  = 10;

  typedef struct {
    int bank;
    int k;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NBANK-1:0] i_bank_done = '0;
  logic [1:0]       i_k_sel = 2'd0;
  logic             fifo_overflow = 1'b0;
  logic             rom_en, fetch_en, rsc_en, o_term, enc_start, enc_done, alert;
  logic [NBANK-1:0] o_bank_ack;
  logic [1:0]       o_bank_sel;
  logic [13:0]      o_k;
  logic             soft_rst, data_in_ctrl;
`ifdef TURBO_ENC_FRAME_CNT_EN
  logic [15:0]      o_frame_cnt;
  logic [7:0]       o_abort_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  turbo_enc_mb_ctrl #(
    .NBANK(NBANK), .PIPE_LAT(PIPE_LAT), .TERM_LEN(TERM_LEN),
    .WARN_CYC(WARN_CYC), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk), .rst(rst), .i_bank_done(i_bank_done), .i_k_sel(i_k_sel),
    .fifo_overflow(fifo_overflow), .rom_en(rom_en), .fetch_en(fetch_en),
    .rsc_en(rsc_en), .o_term(o_term), .enc_start(enc_start), .enc_done(enc_done),
    .alert(alert), .o_bank_ack(o_bank_ack), .o_bank_sel(o_bank_sel), .o_k(o_k),
    .soft_rst(soft_rst), .data_in_ctrl(data_in_ctrl)
`ifdef TURBO_ENC_FRAME_CNT_EN
    , .o_frame_cnt(o_frame_cnt), .o_abort_cnt(o_abort_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output bit ok, output int gap);
    ok  = 1'b0;
    gap = 0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      gap++;
      if (enc_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("enc_start_timeout", 32'd0, 32'd1);
  endtask

  // Follows one frame from enc_start to its bank ack and checks it against the scoreboard head.
  task automatic run_frame(input int ksel_change, output int gap);
    exp_t e;
    bit   ok;
    int   rom_n, rom_last, fetch_n, rsc_n, term_n, done_cyc, starts;
    logic [NBANK-1:0] ack_v;
    wait_start(ok, gap);
    if (!ok) return;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    check("bank_sel", 32'(o_bank_sel), e.bank);
    check("o_k", 32'(o_k), e.k);
    rom_n = 0; rom_last = -1; fetch_n = 0; rsc_n = 0; term_n = 0;
    done_cyc = -1; starts = 0; ack_v = '0;
    for (int c = 0; c < 12000; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 10 && ksel_change >= 0) i_k_sel = 2'(ksel_change);
      if (rom_en) begin rom_n++; rom_last = c; end
      if (fetch_en) fetch_n++;
      if (rsc_en) rsc_n++;
      if (o_term) term_n++;
      if (enc_start) starts++;
      if (enc_done && done_cyc < 0) done_cyc = c;
      if (|o_bank_ack) begin
        ack_v = o_bank_ack;
        break;
      end
    end
    check("rom_en_cycles", rom_n, e.k);
    check("rom_en_last", rom_last, e.k - 1);
    check("fetch_en_cycles", fetch_n, e.k);
    check("rsc_en_cycles", rsc_n, e.k);
    check("enc_done_cycle", done_cyc, e.k + PIPE_LAT - 1);
    check("term_cycles", term_n, TERM_LEN);
    check("enc_start_pulses", starts, 1);
    check("bank_ack", 32'(ack_v), 32'(1) << e.bank);
    i_bank_done[e.bank] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int gap, n, alert_n, srst_n, srst_last, dic_low, ack_n;

    repeat (3) @(negedge clk);
    check("rst_1bit_outs", 32'({rom_en, fetch_en, rsc_en, o_term, enc_start, enc_done, alert, soft_rst}), 32'd0);
    check("rst_data_in_ctrl", 32'(data_in_ctrl), 32'd1);
    check("rst_o_k", 32'(o_k), 32'd8920);
    check("rst_bank_sel", 32'(o_bank_sel), 32'd0);
    check("rst_bank_ack", 32'(o_bank_ack), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start", 32'(enc_start), 32'd0);

    // Bank 0 first after reset; k_sel moves to 3 mid-frame and must not matter.
    i_bank_done = 4'b0001;
    sbq.push_back('{0, 1784});
    run_frame(3, gap);

    // Next frame picks up the new block length.
    repeat (2) @(negedge clk);
    i_bank_done = 4'b0010;
    sbq.push_back('{1, 8920});
    run_frame(-1, gap);

    // last_served = 1 with banks 1 and 3 ready: 3 then 1, back-to-back.
    repeat (2) @(negedge clk);
    i_k_sel = 2'd0;
    i_bank_done = 4'b1010;
    sbq.push_back('{3, 1784});
    sbq.push_back('{1, 1784});
    run_frame(-1, gap);
    run_frame(-1, gap);
    check("back_to_back_gap", gap, 1);

    // Overflow at rsc count 500.
    repeat (2) @(negedge clk);
    i_bank_done = 4'b0001;
    wait_start(ok, gap);
    check("ovf_frame_bank", 32'(o_bank_sel), 32'd0);
    n = 0;
    for (int c = 0; c < 3000 && n < 500; c++) begin
      @(negedge clk);
      if (rsc_en) n++;
    end
    check("ovf_rsc_reached", n, 500);
    fifo_overflow = 1'b1;
    i_bank_done = '0;
    @(negedge clk);
    fifo_overflow = 1'b0;
    check("warn_enables_low", 32'({rom_en, fetch_en, rsc_en, o_term}), 32'd0);
    check("warn_alert_first", 32'(alert), 32'd1);
    check("warn_soft_rst_first", 32'(soft_rst), 32'd1);
    check("warn_dic_lag", 32'(data_in_ctrl), 32'd1);
    alert_n = 0; srst_n = 0; srst_last = -1; dic_low = 0; ack_n = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 100) fifo_overflow = 1'b1;
      if (c == 101) fifo_overflow = 1'b0;
      if (|o_bank_ack) ack_n++;
      if (!alert) break;
      alert_n++;
      if (soft_rst) begin srst_n++; srst_last = c; end
      if (!data_in_ctrl) dic_low++;
    end
    check("warn_alert_cycles", alert_n, WARN_CYC + 1);
    check("warn_soft_rst_cycles", srst_n, RST_CYC);
    check("warn_soft_rst_last", srst_last, RST_CYC - 1);
    check("warn_dic_low_in_warn", dic_low, WARN_CYC);
    check("warn_no_ack", ack_n, 0);
    check("warn_exit_dic_still_low", 32'(data_in_ctrl), 32'd0);
    check("warn_exit_idle", 32'({enc_start, o_term, rom_en}), 32'd0);
    @(negedge clk);
    check("warn_exit_dic_high", 32'(data_in_ctrl), 32'd1);
`ifdef TURBO_ENC_FRAME_CNT_EN
    check("abort_cnt", 32'(o_abort_cnt), 32'd1);
`endif

    // Priority restarts at bank 0 after WARN: banks 1 and 2 ready -> 1 then 2.
    i_bank_done = 4'b0110;
    sbq.push_back('{1, 1784});
    sbq.push_back('{2, 1784});
    run_frame(-1, gap);
    run_frame(-1, gap);
    check("post_warn_b2b_gap", gap, 1);

    // Reset during TERM aborts the frame with no ack.
    repeat (2) @(negedge clk);
    i_bank_done = 4'b0100;
    wait_start(ok, gap);
    n = 0;
    for (int c = 0; c < 12000 && n < 2; c++) begin
      @(negedge clk);
      if (o_term) n++;
    end
    check("term_reached", n, 2);
    check("term_bank_sel", 32'(o_bank_sel), 32'd2);
`ifdef TURBO_ENC_FRAME_CNT_EN
    check("frame_cnt", 32'(o_frame_cnt), 32'd6);
`endif
    rst = 1'b1;
    #1;
    check("mid_rst_1bit_outs", 32'({rom_en, fetch_en, rsc_en, o_term, enc_start, enc_done, alert, soft_rst}), 32'd0);
    check("mid_rst_bank_ack", 32'(o_bank_ack), 32'd0);
    check("mid_rst_bank_sel", 32'(o_bank_sel), 32'd0);
    check("mid_rst_o_k", 32'(o_k), 32'd8920);
    check("mid_rst_dic", 32'(data_in_ctrl), 32'd1);
`ifdef TURBO_ENC_FRAME_CNT_EN
    check("mid_rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
`endif
    i_bank_done = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'({enc_start, o_term, alert, rom_en}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/turbo_enc_mb_ctrl.md
TURBO_ENC_MB_CTRL -- requirements
Module: turbo_enc_mb_ctrl

Interface
REQ-001 SHALL have parameter NBANK, default 2, number of input frame RAM banks (2..8).
REQ-002 SHALL have parameter PIPE_LAT, default 2, cycles from rom_en to rsc_en (1..4).
REQ-003 SHALL have parameter TERM_LEN, default 4, trellis termination cycles.
REQ-004 SHALL have parameters WARN_CYC, default 1000, and RST_CYC, default 10: warning and soft-reset durations in cycles.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: i_bank_done  in  NBANK  level, bank b holds a full frame; i_k_sel  in  2  block length select; fifo_overflow  in  1  input FIFO overflow.
REQ-007 SHALL have ports: rom_en, fetch_en, rsc_en, o_term, enc_start, enc_done, alert  out  1 each; o_bank_ack  out  NBANK  one-cycle release pulse; o_bank_sel  out  clog2(NBANK)  bank being encoded; o_k  out  14  active block length; soft_rst  out  1  active-high downstream reset; data_in_ctrl  out  1  FIFO write permit.

Function
REQ-008 SHALL implement states IDLE, ENC, TERM, WARN.
REQ-009 SHALL, in IDLE with any i_bank_done bit set and no overflow, select the lowest-indexed ready bank at or after (last_served+1) mod NBANK (round-robin), drive o_bank_sel to it, latch o_k, and enter ENC.
REQ-010 SHALL map i_k_sel 0/1/2/3 to K = 1784/3568/7136/8920, sampled only at frame start; changes mid-frame ignored.
REQ-011 SHALL assert rom_en for exactly K consecutive cycles starting the first ENC cycle; fetch_en = rom_en delayed 1 cycle; rsc_en = rom_en delayed PIPE_LAT cycles.
REQ-012 SHALL count rsc_en cycles 0..K-1; on count K-1 pulse enc_done for one cycle and enter TERM next cycle.
REQ-013 SHALL pulse enc_start for one cycle on the first cycle of each ENC, including back-to-back frames.
REQ-014 SHALL hold o_term high for exactly TERM_LEN cycles in TERM; on the last TERM cycle pulse o_bank_ack for the served bank and update last_served.
REQ-015 SHALL, after TERM, go directly to ENC if another bank (excluding the one just acked) is ready, with no IDLE cycle, else IDLE.
REQ-016 SHALL, on fifo_overflow in IDLE/ENC/TERM, enter WARN next cycle; rom_en/fetch_en/rsc_en/o_term deassert that cycle, pipeline delay registers clear, no o_bank_ack for the aborted frame.
REQ-017 SHALL stay in WARN WARN_CYC+1 cycles, then IDLE; alert high throughout WARN; soft_rst high for the first RST_CYC WARN cycles; fifo_overflow ignored in WARN.
REQ-018 SHALL drive data_in_ctrl low, registered one cycle after state, for the whole WARN duration, high otherwise.
REQ-019 SHALL reset last_served to NBANK-1 on WARN exit so bank 0 has priority.
REQ-020 SHALL keep soft_rst internal-only in effect: the block's own state is never cleared by soft_rst.

Reset
REQ-021 SHALL on rst: state IDLE, all counters 0, last_served NBANK-1, o_k 8920, all 1-bit outputs 0 except data_in_ctrl 1; o_bank_ack 0, o_bank_sel 0.
REQ-022 SHALL abort any frame instantly on rst assertion mid-operation, with no ack issued.

Configuration
REQ-023 SHALL, with TURBO_ENC_FRAME_CNT_EN defined, add output o_frame_cnt (16 bits, reset 0) incrementing on each o_bank_ack, wrapping 65535->0, and o_abort_cnt (8 bits, saturating at 255) incrementing on each WARN entry from ENC/TERM.
REQ-024 SHALL, without TURBO_ENC_FRAME_CNT_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-025 NBANK=2, i_k_sel=0, bank0 ready -> rom_en 1784 cycles, enc_done at cycle 1784+PIPE_LAT-1 after enc_start, o_term 4 cycles, o_bank_ack=01.
REQ-026 NBANK=4, banks 1 and 3 ready, last_served=1 -> bank 3 served first, then bank 1 back-to-back, no IDLE between.
REQ-027 fifo_overflow mid-ENC at rsc count 500 -> WARN next cycle, enables low, no ack, soft_rst high 10 cycles, alert 1001 cycles, then IDLE.
REQ-028 i_k_sel changed 0->3 mid-frame -> current frame still 1784 rsc_en cycles; next frame 8920.
REQ-029 rst asserted in TERM -> all outputs at reset values same cycle; with TURBO_ENC_FRAME_CNT_EN, 3 completed frames -> o_frame_cnt=3.
